// File: rtl/flag_buf_arbiter.sv
// flag_buf_arbiter: round-robin arbitration of N producers into one single-entry flag buffer
//   Optional feature macro: FLAG_OWNER_EN (adds the owner port and register)
//   Ports:
//     clk      - system clock, rising edge
//     reset_n  - asynchronous active-low reset
//     req      - per-requester request, word valid on its din slice
//     din      - packed words, requester i on din[i*W +: W]
//     ack      - one-cycle accept pulse for the granted requester
//     clr_flag - consumer has taken dout, empties the buffer
//     flag     - buffer holds a valid word
//     dout     - buffered word
//     owner    - index of the requester that loaded dout (FLAG_OWNER_EN only)
module flag_buf_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   din,
    output logic [N-1:0]     ack,
    input  logic             clr_flag,
    output logic             flag,
    output logic [W-1:0]     dout
`ifdef FLAG_OWNER_EN
    ,
    output logic [$clog2(N)-1:0] owner
`endif
);
    localparam int PW = $clog2(N);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt, idx;
    logic            found;
    logic [W-1:0]    dout_d;
    logic [N-1:0]    ack_d;
    logic [W-1:0]    words [N];

    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g] = din[g*W +: W];
    end

    assign flag = (state_q == FULL);

    // Search starts just after the last winner so every requester gets a turn within N grants.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dout_d  = dout;
        ack_d   = '0;
        if (state_q == EMPTY && found) begin
            state_d    = FULL;
            ptr_d      = gnt;
            dout_d     = words[gnt];
            ack_d[gnt] = 1'b1;
        end else if (state_q == FULL && clr_flag) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            ptr_q   <= PW'(N - 1);
            dout    <= '0;
            ack     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout    <= dout_d;
            ack     <= ack_d;
        end
    end

`ifdef FLAG_OWNER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            owner <= '0;
        else if (state_q == EMPTY && found)
            owner <= gnt;
    end
`endif

endmodule

// File: tb/tb_flag_buf_arbiter.sv
// tb_flag_buf_arbiter: scoreboard bench for flag_buf_arbiter
module tb_flag_buf_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           clr_flag = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   ack;
    logic [N*W-1:0] din = '0;
    logic           flag;
    logic [W-1:0]   dout;
`ifdef FLAG_OWNER_EN
    logic [1:0]     owner;
`endif

    typedef struct {
        int         idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   ack_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    flag_buf_arbiter #(.N(N), .W(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .din(din),
        .ack(ack),
        .clr_flag(clr_flag),
        .flag(flag),
        .dout(dout)
`ifdef FLAG_OWNER_EN
        ,
        .owner(owner)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_grant(input int i, input logic [W-1:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (ack != '0) begin
            exp_t e;
            ack_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack", 32'(ack), 32'd1 << e.idx);
                check("dout", 32'(dout), 32'(e.data));
                check("flag_with_ack", 32'(flag), 32'd1);
            end
        end
    end

    initial begin
        cyc(2);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        reset_n = 1'b1;

        din[7:0] = 8'hA5;
        req = 4'b0001;
        expect_grant(0, 8'hA5);
        cyc(1);
        req = '0;
        cyc(1);
        check("t1_ack_low", 32'(ack), 32'd0);
        check("t1_flag", 32'(flag), 32'd1);
        check("t1_dout", 32'(dout), 32'hA5);

        din[15:8] = 8'h5B;
        req = 4'b0010;
        repeat (5) begin
            cyc(1);
            check("t2_full_no_ack", 32'(ack), 32'd0);
        end
        check("t2_dout_held", 32'(dout), 32'hA5);
        expect_grant(1, 8'h5B);
        clr_flag = 1'b1;
        cyc(1);
        clr_flag = 1'b0;
        check("t2_clr_flag", 32'(flag), 32'd0);
        check("t2_dout_kept", 32'(dout), 32'hA5);
        check("t2_no_bypass", 32'(ack), 32'd0);
        cyc(1);
        req = '0;

        req = 4'b1000;
        cyc(2);
        req = '0;
        clr_flag = 1'b1;
        cyc(1);
        clr_flag = 1'b0;
        cyc(3);
        check("withdraw_flag", 32'(flag), 32'd0);

        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        din = {8'h13, 8'h12, 8'h11, 8'h10};
        expect_grant(0, 8'h10);
        expect_grant(1, 8'h11);
        expect_grant(2, 8'h12);
        expect_grant(3, 8'h13);
        expect_grant(0, 8'h10);
        base = ack_cnt;
        req = 4'b1111;
        repeat (9) begin
            clr_flag = flag;
            cyc(1);
        end
        check("t3_five_grants_in_9", 32'(ack_cnt - base), 32'd5);
        req = '0;
        clr_flag = 1'b1;
        cyc(1);
        clr_flag = 1'b0;

        expect_grant(3, 8'h13);
        expect_grant(0, 8'h10);
        req = 4'b1001;
        repeat (3) begin
            clr_flag = flag;
            cyc(1);
        end
        req = '0;
        clr_flag = 1'b1;
        cyc(1);
        clr_flag = 1'b0;

        din[23:16] = 8'h3C;
        req = 4'b0100;
        expect_grant(2, 8'h3C);
        cyc(1);
        req = '0;
        check("t5_dout", 32'(dout), 32'h3C);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_flag", 32'(flag), 32'd0);
        check("t5_async_dout", 32'(dout), 32'd0);
        check("t5_async_ack", 32'(ack), 32'd0);
`ifdef FLAG_OWNER_EN
        check("t5_async_owner", 32'(owner), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        din[23:16] = 8'h77;
        req = 4'b0100;
        expect_grant(2, 8'h77);
        cyc(1);
        req = '0;
`ifdef FLAG_OWNER_EN
        check("t6_owner", 32'(owner), 32'd2);
`endif
        clr_flag = 1'b1;
        cyc(1);
        clr_flag = 1'b0;
        check("t6_flag_cleared", 32'(flag), 32'd0);
`ifdef FLAG_OWNER_EN
        check("t6_owner_held", 32'(owner), 32'd2);
`endif

        cyc(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
